// File: rtl/alu4_exec_unit.sv
// Buffered 4-bit, 8-operation ALU: commands queue in a small FIFO, and results leave
// through a registered valid/ready output stage with an accepted-result counter.
module alu4_exec_unit #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_a,
    input  logic [3:0]    in_b,
    input  logic          in_cin,
    input  logic [2:0]    in_m,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_r,
    output logic          out_of,
    output logic [CW-1:0] level,
    output logic [7:0]    ops_done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
    localparam logic [CW-1:0] LVL_ONE   = CW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_CMP = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_INC = 3'b110;
    localparam logic [2:0] OP_DEC = 3'b111;

    // Returns {flag, result}; the 5-bit sum's MSB doubles as carry or borrow.
    function automatic logic [4:0] alu_eval(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       cin,
        input logic [2:0] m
    );
        logic [4:0] sum_s;
        logic [3:0] r_s;
        logic       of_s;
        sum_s = 5'd0;
        r_s   = 4'd0;
        of_s  = 1'b0;
        case (m)
            OP_ADD: begin
                sum_s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
                r_s   = sum_s[3:0];
                of_s  = sum_s[4];
            end
            OP_SUB: begin
                sum_s = {1'b0, a} - {1'b0, b};
                r_s   = sum_s[3:0];
                of_s  = sum_s[4];
            end
            OP_CMP: begin
                r_s  = {1'b0, (a > b), (a == b), (a < b)};
                of_s = 1'b0;
            end
            OP_AND: begin
                r_s  = a & b;
                of_s = 1'b0;
            end
            OP_OR: begin
                r_s  = a | b;
                of_s = 1'b0;
            end
            OP_NOT: begin
                r_s  = ~a;
                of_s = 1'b0;
            end
            OP_INC: begin
                sum_s = {1'b0, a} + 5'd1;
                r_s   = sum_s[3:0];
                of_s  = sum_s[4];
            end
            OP_DEC: begin
                sum_s = {1'b0, a} - 5'd1;
                r_s   = sum_s[3:0];
                of_s  = sum_s[4];
            end
            default: begin
                r_s  = 4'd0;
                of_s = 1'b0;
            end
        endcase
        return {of_s, r_s};
    endfunction

    logic [11:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] level_r;
    logic [CW-1:0] level_nxt_s;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [3:0]    out_r_r;
    logic          out_of_r;
    logic [7:0]    ops_done_r;

    logic          push_s;
    logic          pop_s;
    logic          accept_s;
    logic [11:0]   head_s;
    logic [4:0]    eval_s;

    // Handshake decode and head evaluation; in_ready comes from a register only.
    always_comb begin
        push_s   = in_valid & in_ready_r;
        pop_s    = (level_r != {CW{1'b0}}) & (~out_valid_r | out_ready);
        accept_s = out_valid_r & out_ready;
        head_s   = mem_r[rd_ptr_r];
        eval_s   = alu_eval(head_s[11:8], head_s[7:4], head_s[3], head_s[2:0]);
    end

    // Next fill level from the push/pop pair.
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_ONE;
            2'b01:   level_nxt_s = level_r - LVL_ONE;
            default: level_nxt_s = level_r;
        endcase
    end

    // Command storage; entries are not cleared since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {in_a, in_b, in_cin, in_m};
        end
    end

    // Pointers, level and the registered ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            level_r    <= {CW{1'b0}};
            in_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r    <= level_nxt_s;
            in_ready_r <= (level_nxt_s != FULL_LVL);
        end
    end

    // Result register: load on pop, otherwise drop valid once the held result is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_r_r     <= 4'd0;
            out_of_r    <= 1'b0;
        end else if (pop_s) begin
            out_valid_r <= 1'b1;
            out_r_r     <= eval_s[3:0];
            out_of_r    <= eval_s[4];
        end else if (accept_s) begin
            out_valid_r <= 1'b0;
        end
    end

    // Accepted-result counter, wraps naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            ops_done_r <= 8'd0;
        end else if (accept_s) begin
            ops_done_r <= ops_done_r + 8'd1;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_r     = out_r_r;
    assign out_of    = out_of_r;
    assign level     = level_r;
    assign ops_done  = ops_done_r;

endmodule

// File: doc/alu4_exec_unit.md
Name: alu4_exec_unit

Overview:
Buffered, handshaked execution wrapper for the 4-bit, 8-operation ALU function set.
- Command side: accepts operation commands (a, b, cin, mode) on a valid/ready interface into an internal command FIFO.
- Result side: evaluates the head command and returns result plus overflow/carry flag on a registered valid/ready interface.
- Use: sits between a command sequencer (or bench driver) and a result consumer, so ALU work can be streamed with back-pressure on both sides.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- CW, 3, width of the fill-level output; CW = log2(DEPTH)+1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  command present.
- in_ready  out  1  FIFO can accept a command.
- in_a  in  4  operand A.
- in_b  in  4  operand B.
- in_cin  in  1  carry-in (used by add only).
- in_m  in  3  operation mode.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  consumer accepts the result.
- out_r  out  4  result.
- out_of  out  1  carry/borrow/overflow flag.
- level  out  CW  number of commands in FIFO (excludes output register).
- ops_done  out  8  count of results accepted by consumer; wraps 255->0.

Behaviour:
- Reset (rst=1 at an edge): FIFO empty, level=0, in_ready=1, out_valid=0, out_r=0, out_of=0, ops_done=0. Reset mid-operation discards all queued commands and any held result.
- Push: in_valid & in_ready at an edge writes {a,b,cin,m} at the write pointer. in_ready = (level != DEPTH), registered-state only, with no combinational path from out_ready.
- Pop/evaluate: at an edge where FIFO is non-empty and (out_valid==0 or out_ready==1):
  - head is popped;
  - out_r/out_of are loaded with the evaluated result;
  - out_valid=1.
- Output drain: at an edge where out_valid & out_ready and the FIFO is empty, out_valid goes to 0. out_r/out_of hold their last value.
- Latency: command accepted at edge T into an empty unit -> out_valid=1 after edge T+1. No bypass from input to output in the same edge.
- Throughput: 1 command/cycle sustained when out_ready=1 continuously.
- Simultaneous push and pop at the same edge: level unchanged; pointers both advance.
- Full: level==DEPTH -> in_ready=0; in_valid ignored.
- Empty: no pop occurs; out_valid falls only per the drain rule.
- Pointers wrap modulo DEPTH.
- ops_done increments on every out_valid & out_ready edge.
- Held result: while out_valid=1 and out_ready=0, out_r/out_of are stable.
- Mode evaluation (unsigned, 4-bit, 5-bit internal sum):
  - 000 add: r = a+b+cin; of = carry out.
  - 001 sub: r = a-b (cin ignored); of = 1 if a<b (borrow).
  - 010 compare: r = {0, a>b, a==b, a<b}; of = 0.
  - 011 and: r = a&b; of = 0.
  - 100 or: r = a|b; of = 0.
  - 101 complement: r = ~a; of = 0.
  - 110 increment: r = a+1; of = (a==15).
  - 111 decrement: r = a-1; of = (a==0).

Test Plan:
- Reset then single add a=1111, b=0001, cin=0, out_ready=1 -> out_valid one cycle after accept, r=0000, of=1; ops_done=1.
- Sweep all modes with out_ready=1:
  - sub a=0111, b=1100 -> r=1011, of=1;
  - compare a=1010, b=0101 -> r=0100;
  - complement a=1001 -> r=0110;
  - decrement a=0000 -> r=1111, of=1;
  - increment a=1010 -> r=1011, of=0.
- Back-pressure: out_ready=0, push 5 commands -> 1 in output reg, level=4, in_ready=0 after 5th accept; 6th in_valid ignored. Then out_ready=1 -> results drain in order, one per cycle; ops_done=5.
- Streaming: in_valid=1 and out_ready=1 for 20 cycles with random ops -> no bubbles after first result, level stays <=1, results match golden model in order.
- Simultaneous push/pop at level=2 -> level stays 2; pointer wrap exercised over >DEPTH pushes without data corruption.
- Assert rst while level=3 and out_valid=1 -> next cycle level=0, out_valid=0, in_ready=1, ops_done=0; a subsequent add 0010+0011 -> r=0101, of=0.
